// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART: parity modes, FSM encodings
// and the frame parity helper used by both the transmitter and the receiver.
`timescale 1ns/1ps
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    typedef enum logic [2:0] {
        TX_IDLE  = 3'd0,
        TX_START = 3'd1,
        TX_DATA  = 3'd2,
        TX_PAR   = 3'd3,
        TX_STOP  = 3'd4
    } tx_state_e;

    typedef enum logic [2:0] {
        RX_IDLE  = 3'd0,
        RX_START = 3'd1,
        RX_DATA  = 3'd2,
        RX_PAR   = 3'd3,
        RX_STOP  = 3'd4
    } rx_state_e;

    // Narrower frames are zero-extended by the caller, which leaves the XOR unchanged.
    function automatic logic calc_parity(input logic [7:0] data, input int mode);
        logic par;
        if (mode == PARITY_EVEN) begin
            par = ^data;
        end else if (mode == PARITY_ODD) begin
            par = ~^data;
        end else begin
            par = 1'b0;
        end
        return par;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Pointer+count synchronous FIFO. Push and pop may coincide at any fill level;
// a push while full is accepted only when a pop frees a slot in the same cycle.
`timescale 1ns/1ps
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push_s, do_pop_s;

    assign full  = (count_q == DEPTH_C);
    assign empty = (count_q == '0);
    assign rdata = mem_q[rd_ptr_q];

    // Next-state for storage, pointers and fill count.
    always_comb begin
        do_pop_s  = pop & ~empty;
        do_push_s = push & (~full | do_pop_s);
        mem_d     = mem_q;
        if (do_push_s) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end else begin
            wr_ptr_d        = wr_ptr_q;
        end
        if (do_pop_s) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // State registers; storage is cleared so the head reads zero out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/uart_fifo_core.sv
// Full-duplex UART with configurable frame format, TX/RX FIFOs, sticky error
// flags and level interrupts. data_in/data_out are the board RX/TX pins.
`timescale 1ns/1ps
module uart_fifo_core #(
    parameter int BAUD_DIV   = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 data_in,
    output logic                 data_out,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 err_parity,
    output logic                 err_frame,
    output logic                 err_overrun,
    input  logic                 err_clr,
    output logic                 Int_T_show,
    output logic                 int_r
);

    import uart_pkg::*;

    localparam int CW = $clog2(BAUD_DIV);
    localparam int BW = $clog2(DATA_BITS) + 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] BAUD_MID  = CW'(BAUD_DIV / 2 - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

    tx_state_e            tx_state_q, tx_state_d;
    logic [CW-1:0]        tx_cnt_q, tx_cnt_d;
    logic [BW-1:0]        tx_bit_q, tx_bit_d;
    logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
    logic                 tx_par_q, tx_par_d;
    logic                 data_out_q, data_out_d;
    logic                 tx_pop_s, tx_tick_s, tx_full_s, tx_empty_s;
    logic [DATA_BITS-1:0] tx_head_s;

    rx_state_e            rx_state_q, rx_state_d;
    logic [CW-1:0]        rx_cnt_q, rx_cnt_d;
    logic [BW-1:0]        rx_bit_q, rx_bit_d;
    logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
    logic                 rx_par_q, rx_par_d;
    logic                 sync1_q, sync2_q, rx_prev_q;
    logic                 rx_push_s, rx_tick_s, rx_full_s, rx_empty_s;
    logic                 set_par_s, set_frame_s, set_ovr_s;
    logic                 err_parity_q, err_parity_d;
    logic                 err_frame_q, err_frame_d;
    logic                 err_overrun_q, err_overrun_d;

    uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (tx_valid),
        .wdata (tx_data),
        .pop   (tx_pop_s),
        .rdata (tx_head_s),
        .full  (tx_full_s),
        .empty (tx_empty_s)
    );

    uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rx_push_s),
        .wdata (rx_shift_q),
        .pop   (rx_ready),
        .rdata (rx_data),
        .full  (rx_full_s),
        .empty (rx_empty_s)
    );

    // Transmit FSM: next state, bit timing and registered line level.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_par_d   = tx_par_q;
        tx_pop_s   = 1'b0;
        tx_tick_s  = (tx_cnt_q == BAUD_LAST);
        if (tx_state_q == TX_IDLE || tx_tick_s) begin
            tx_cnt_d = '0;
        end else begin
            tx_cnt_d = tx_cnt_q + 1'b1;
        end
        case (tx_state_q)
            TX_IDLE: begin
                if (!tx_empty_s) begin
                    tx_pop_s   = 1'b1;
                    tx_shift_d = tx_head_s;
                    tx_par_d   = calc_parity(8'(tx_head_s), PARITY);
                    tx_bit_d   = '0;
                    tx_state_d = TX_START;
                end else begin
                    tx_state_d = TX_IDLE;
                end
            end
            TX_START: begin
                if (tx_tick_s) begin
                    tx_bit_d   = '0;
                    tx_state_d = TX_DATA;
                end else begin
                    tx_state_d = TX_START;
                end
            end
            TX_DATA: begin
                if (tx_tick_s) begin
                    tx_shift_d = tx_shift_q >> 1;
                    if (tx_bit_q == DATA_LAST) begin
                        tx_bit_d   = '0;
                        tx_state_d = (PARITY != PARITY_NONE) ? TX_PAR : TX_STOP;
                    end else begin
                        tx_bit_d   = tx_bit_q + 1'b1;
                    end
                end else begin
                    tx_state_d = TX_DATA;
                end
            end
            TX_PAR: begin
                if (tx_tick_s) begin
                    tx_bit_d   = '0;
                    tx_state_d = TX_STOP;
                end else begin
                    tx_state_d = TX_PAR;
                end
            end
            TX_STOP: begin
                if (tx_tick_s && tx_bit_q == STOP_LAST) begin
                    // Back-to-back: the next frame's start bit follows the last stop bit directly.
                    if (!tx_empty_s) begin
                        tx_pop_s   = 1'b1;
                        tx_shift_d = tx_head_s;
                        tx_par_d   = calc_parity(8'(tx_head_s), PARITY);
                        tx_bit_d   = '0;
                        tx_state_d = TX_START;
                    end else begin
                        tx_state_d = TX_IDLE;
                    end
                end else if (tx_tick_s) begin
                    tx_bit_d = tx_bit_q + 1'b1;
                end else begin
                    tx_state_d = TX_STOP;
                end
            end
            default: begin
                tx_state_d = TX_IDLE;
            end
        endcase
        case (tx_state_d)
            TX_START: data_out_d = 1'b0;
            TX_DATA:  data_out_d = tx_shift_d[0];
            TX_PAR:   data_out_d = tx_par_d;
            default:  data_out_d = 1'b1;
        endcase
    end

    // Receive FSM: start detection, mid-bit sampling, push and error detection.
    always_comb begin
        rx_state_d  = rx_state_q;
        rx_cnt_d    = rx_cnt_q;
        rx_bit_d    = rx_bit_q;
        rx_shift_d  = rx_shift_q;
        rx_par_d    = rx_par_q;
        rx_push_s   = 1'b0;
        set_par_s   = 1'b0;
        set_frame_s = 1'b0;
        set_ovr_s   = 1'b0;
        rx_tick_s   = (rx_cnt_q == BAUD_LAST);
        case (rx_state_q)
            RX_IDLE: begin
                rx_cnt_d = '0;
                if (rx_prev_q && !sync2_q) begin
                    rx_state_d = RX_START;
                end else begin
                    rx_state_d = RX_IDLE;
                end
            end
            RX_START: begin
                if (rx_cnt_q == BAUD_MID) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
                    rx_state_d = sync2_q ? RX_IDLE : RX_DATA;
                end else begin
                    rx_cnt_d   = rx_cnt_q + 1'b1;
                end
            end
            RX_DATA: begin
                if (rx_tick_s) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {sync2_q, rx_shift_q[DATA_BITS-1:1]};
                    if (rx_bit_q == DATA_LAST) begin
                        rx_state_d = (PARITY != PARITY_NONE) ? RX_PAR : RX_STOP;
                    end else begin
                        rx_bit_d   = rx_bit_q + 1'b1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            RX_PAR: begin
                if (rx_tick_s) begin
                    rx_cnt_d   = '0;
                    rx_par_d   = sync2_q;
                    rx_state_d = RX_STOP;
                end else begin
                    rx_cnt_d   = rx_cnt_q + 1'b1;
                end
            end
            RX_STOP: begin
                if (rx_tick_s) begin
                    rx_cnt_d    = '0;
                    rx_state_d  = RX_IDLE;
                    rx_push_s   = 1'b1;
                    set_frame_s = ~sync2_q;
                    set_par_s   = (PARITY != PARITY_NONE) &&
                                  (rx_par_q != calc_parity(8'(rx_shift_q), PARITY));
                    set_ovr_s   = rx_full_s & ~rx_ready;
                end else begin
                    rx_cnt_d    = rx_cnt_q + 1'b1;
                end
            end
            default: begin
                rx_state_d = RX_IDLE;
            end
        endcase
        err_parity_d  = set_par_s   | (err_parity_q  & ~err_clr);
        err_frame_d   = set_frame_s | (err_frame_q   & ~err_clr);
        err_overrun_d = set_ovr_s   | (err_overrun_q & ~err_clr);
    end

    // State registers for both directions, the RX synchroniser and error flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_q    <= TX_IDLE;
            tx_cnt_q      <= '0;
            tx_bit_q      <= '0;
            tx_shift_q    <= '0;
            tx_par_q      <= 1'b0;
            data_out_q    <= 1'b1;
            rx_state_q    <= RX_IDLE;
            rx_cnt_q      <= '0;
            rx_bit_q      <= '0;
            rx_shift_q    <= '0;
            rx_par_q      <= 1'b0;
            sync1_q       <= 1'b1;
            sync2_q       <= 1'b1;
            rx_prev_q     <= 1'b1;
            err_parity_q  <= 1'b0;
            err_frame_q   <= 1'b0;
            err_overrun_q <= 1'b0;
        end else begin
            tx_state_q    <= tx_state_d;
            tx_cnt_q      <= tx_cnt_d;
            tx_bit_q      <= tx_bit_d;
            tx_shift_q    <= tx_shift_d;
            tx_par_q      <= tx_par_d;
            data_out_q    <= data_out_d;
            rx_state_q    <= rx_state_d;
            rx_cnt_q      <= rx_cnt_d;
            rx_bit_q      <= rx_bit_d;
            rx_shift_q    <= rx_shift_d;
            rx_par_q      <= rx_par_d;
            sync1_q       <= data_in;
            sync2_q       <= sync1_q;
            rx_prev_q     <= sync2_q;
            err_parity_q  <= err_parity_d;
            err_frame_q   <= err_frame_d;
            err_overrun_q <= err_overrun_d;
        end
    end

    assign data_out    = data_out_q;
    assign tx_ready    = ~tx_full_s;
    assign rx_valid    = ~rx_empty_s;
    assign err_parity  = err_parity_q;
    assign err_frame   = err_frame_q;
    assign err_overrun = err_overrun_q;
    assign Int_T_show  = tx_empty_s & (tx_state_q == TX_IDLE);
    assign int_r       = ~rx_empty_s | err_parity_q | err_frame_q | err_overrun_q;

endmodule
